serial_frame_transmitter: RTL and testbench

Parallel-to-serial frame transmitter. It accepts a WIDTH-bit word through a Load/Ready handshake and shifts it out on a single line: a start bit, the data bits LSB first, an optional even parity bit, then a stop bit. Each bit is held for DIV clock cycles. It is the sending end of the serial link whose receive side captures bits into enabled D flip-flop registers. It is built from the same enable-register and counter primitives used elsewhere in the design.

---
 rtl/serial_frame_transmitter_if.sv | 27 ++
 rtl/serial_frame_transmitter.sv | 115 +++++++++++
 tb/tb_serial_frame_transmitter.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/serial_frame_transmitter_if.sv
// rtl/serial_frame_transmitter_if.sv - load/ready word handshake plus serial line outputs
// The master side offers a word; the slave side owns the line, ready and done.
interface serial_frame_transmitter_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] data;
  logic             load;
  logic             ready;
  logic             serial_out;
  logic             done;

  modport master (
    output data,
    output load,
    input  ready,
    input  serial_out,
    input  done
  );

  modport slave (
    input  data,
    input  load,
    output ready,
    output serial_out,
    output done
  );
endinterface

// File: rtl/serial_frame_transmitter.sv
// rtl/serial_frame_transmitter.sv - start/data(LSB first)/optional even parity/stop serialiser
// Every bit is held for DIV clocks; all outputs are registered.
module serial_frame_transmitter #(
  parameter int WIDTH  = 8,
  parameter int DIV    = 4,
  parameter int PARITY = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  serial_frame_transmitter_if.slave bus
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shifted;
  logic [BW-1:0]    bit_cnt;
  logic [CW-1:0]    div_cnt;
  logic             parity_bit;
  logic             serial_q;
  logic             ready_q;
  logic             done_q;
  logic             bit_end;

  assign bit_end        = (div_cnt == DIV_LAST);
  assign shifted        = shreg >> 1;
  assign bus.serial_out = serial_q;
  assign bus.ready      = ready_q;
  assign bus.done       = done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      div_cnt    <= '0;
      parity_bit <= 1'b0;
      serial_q   <= 1'b1;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state != S_IDLE) begin
        div_cnt <= bit_end ? '0 : div_cnt + 1'b1;
      end
      case (state)
        S_IDLE: begin
          div_cnt <= '0;
          if (bus.load) begin
            shreg      <= bus.data;
            parity_bit <= ^bus.data;
            state      <= S_START;
            serial_q   <= 1'b0;
            ready_q    <= 1'b0;
          end
        end
        S_START: begin
          if (bit_end) begin
            state    <= S_DATA;
            bit_cnt  <= '0;
            serial_q <= shreg[0];
          end
        end
        S_DATA: begin
          if (bit_end) begin
            shreg <= shifted;
            if (bit_cnt == BIT_LAST) begin
              // Parity slot is skipped entirely when the parameter disables it.
              if (PARITY != 0) begin
                state    <= S_PARITY;
                serial_q <= parity_bit;
              end else begin
                state    <= S_STOP;
                serial_q <= 1'b1;
              end
            end else begin
              bit_cnt  <= bit_cnt + 1'b1;
              serial_q <= shifted[0];
            end
          end
        end
        S_PARITY: begin
          if (bit_end) begin
            state    <= S_STOP;
            serial_q <= 1'b1;
          end
        end
        S_STOP: begin
          if (bit_end) begin
            state    <= S_IDLE;
            serial_q <= 1'b1;
            ready_q  <= 1'b1;
            done_q   <= 1'b1;
          end
        end
        default: begin
          state    <= S_IDLE;
          serial_q <= 1'b1;
          ready_q  <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_frame_transmitter.sv
// tb/tb_serial_frame_transmitter.sv - scoreboard bench for three transmitter configurations
// Expected {line, ready, done} per cycle are queued at each accepted load and popped on negedge.
module tb_serial_frame_transmitter;
  logic clk;
  logic rst_n;
  int   tests;
  int   errors;

  localparam int W[3]  = '{8, 8, 1};
  localparam int DV[3] = '{4, 4, 1};
  localparam int PR[3] = '{0, 1, 1};

  serial_frame_transmitter_if #(.WIDTH(8)) if0 ();
  serial_frame_transmitter_if #(.WIDTH(8)) if1 ();
  serial_frame_transmitter_if #(.WIDTH(1)) if2 ();

  serial_frame_transmitter #(.WIDTH(8), .DIV(4), .PARITY(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
  serial_frame_transmitter #(.WIDTH(8), .DIV(4), .PARITY(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  serial_frame_transmitter #(.WIDTH(1), .DIV(1), .PARITY(1)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));

  logic [2:0] obs [3];
  logic [2:0] exp_q [3][$];

  assign obs[0] = {if0.serial_out, if0.ready, if0.done};
  assign obs[1] = {if1.serial_out, if1.ready, if1.done};
  assign obs[2] = {if2.serial_out, if2.ready, if2.done};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_frame(input int d, input logic [7:0] v);
    logic [7:0] m;
    logic       p;
    m = (W[d] == 8) ? v : {7'b0, v[0]};
    p = ^m;
    for (int c = 0; c < DV[d]; c++) exp_q[d].push_back(3'b000);
    for (int i = 0; i < W[d]; i++)
      for (int c = 0; c < DV[d]; c++) exp_q[d].push_back({m[i], 2'b00});
    if (PR[d] != 0)
      for (int c = 0; c < DV[d]; c++) exp_q[d].push_back({p, 2'b00});
    for (int c = 0; c < DV[d]; c++) exp_q[d].push_back(3'b100);
    exp_q[d].push_back(3'b111);
  endtask

  task automatic drive(input int d, input logic ld, input logic [7:0] v);
    case (d)
      0: begin if0.load = ld; if0.data = v; end
      1: begin if1.load = ld; if1.data = v; end
      default: begin if2.load = ld; if2.data = v[0]; end
    endcase
  endtask

  // Called at posedge+1; the load is taken on the next edge and the frame queued right after it.
  task automatic send(input int d, input logic [7:0] v);
    drive(d, 1'b1, v);
    @(posedge clk);
    #1;
    push_frame(d, v);
    drive(d, 1'b0, v);
  endtask

  task automatic wait_drain(input int d, input int budget);
    int n;
    n = 0;
    while (exp_q[d].size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (exp_q[d].size() != 0) check($sformatf("dut%0d drain timeout", d), 32'(exp_q[d].size()), 0);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (!rst_n) check($sformatf("dut%0d reset", d), 32'(obs[d]), 32'(3'b110));
      else if (exp_q[d].size() != 0) check($sformatf("dut%0d line", d), 32'(obs[d]), 32'(exp_q[d].pop_front()));
      else check($sformatf("dut%0d idle", d), 32'(obs[d]), 32'(3'b110));
    end
  end

  initial begin
    int n;
    tests  = 0;
    errors = 0;
    for (int d = 0; d < 3; d++) drive(d, 1'b0, 8'h00);
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    // Load asserted under reset must not start a frame.
    drive(2, 1'b1, 8'h01);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(2, 1'b0, 8'h00);
    repeat (10) @(posedge clk);
    #1;

    send(0, 8'hA5);
    wait_drain(0, 100);

    send(1, 8'hA5);
    wait_drain(1, 100);
    send(1, 8'h07);
    wait_drain(1, 100);

    send(2, 8'h01);
    wait_drain(2, 20);

    // Busy loads are ignored; a load held through Done starts the next frame one cycle later.
    send(0, 8'hA5);
    repeat (10) @(posedge clk);
    #1;
    drive(0, 1'b1, 8'hFF);
    repeat (5) @(posedge clk);
    #1;
    drive(0, 1'b1, 8'h3C);
    n = 0;
    while (if0.done !== 1'b1 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (if0.done !== 1'b1) check("dut0 done timeout", 32'(if0.done), 1);
    send(0, 8'h3C);
    wait_drain(0, 100);

    // Reset during data bit 3 of an all-zero frame.
    send(0, 8'h00);
    repeat (17) @(posedge clk);
    #2;
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) exp_q[d].delete();
    #1;
    check("dut0 async reset line", 32'(obs[0]), 32'(3'b110));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(0, 8'h5A);
    wait_drain(0, 100);
    send(2, 8'h00);
    wait_drain(2, 20);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule
